// File: rtl/instr_queue.sv
// Decoupling FIFO between control_unit and the execution/memory units.
// Registered first-word fall-through head with occupancy status and a sticky overflow flag.
module instr_queue #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 18,
    parameter int TYPE_W  = 2,
    parameter int INSTR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     queue_we,
    input  logic [TYPE_W-1:0]        queue_instr_type,
    input  logic [ADDR_W-1:0]        cache_addr,
    input  logic [ADDR_W-1:0]        main_mem_addr,
    input  logic [ADDR_W-1:0]        d_cache_addr,
    input  logic [ADDR_W-1:0]        d_main_mem_addr,
    input  logic [INSTR_W-1:0]       raw_instruction,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TYPE_W-1:0]        out_instr_type,
    output logic [ADDR_W-1:0]        out_cache_addr,
    output logic [ADDR_W-1:0]        out_main_mem_addr,
    output logic [ADDR_W-1:0]        out_d_cache_addr,
    output logic [ADDR_W-1:0]        out_d_main_mem_addr,
    output logic [INSTR_W-1:0]       out_raw_instruction,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = TYPE_W + 4 * ADDR_W + INSTR_W;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head;
    logic [EW-1:0] head_n;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_n;
    logic [PW-1:0] wr_n;
    logic [PW-1:0] count_n;
    logic          full_n;
    logic          pop;
    logic          push;

    assign in_entry = {queue_instr_type, cache_addr, main_mem_addr,
                       d_cache_addr, d_main_mem_addr, raw_instruction};

    assign {out_instr_type, out_cache_addr, out_main_mem_addr,
            out_d_cache_addr, out_d_main_mem_addr, out_raw_instruction} = head;

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push      = queue_we & (~full | pop);

    always_comb begin
        rd_n    = rd_ptr + PW'(pop);
        wr_n    = wr_ptr + PW'(push);
        count_n = wr_n - rd_n;
        full_n  = (wr_n[AW] != rd_n[AW]) && (wr_n[AW-1:0] == rd_n[AW-1:0]);
        // The head register is loaded with next cycle's head entry; an entry being
        // written into the head slot this cycle is taken straight from the inputs.
        if (wr_n == rd_n) begin
            head_n = '0;
        end else if (push && (wr_ptr[AW-1:0] == rd_n[AW-1:0])) begin
            head_n = in_entry;
        end else begin
            head_n = mem[rd_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            empty       <= 1'b1;
            overflow    <= 1'b0;
            head        <= '0;
        end else if (flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            empty       <= 1'b1;
            overflow    <= 1'b0;
            head        <= '0;
        end else begin
            rd_ptr      <= rd_n;
            wr_ptr      <= wr_n;
            count       <= count_n;
            full        <= full_n;
            almost_full <= (count_n >= PW'(DEPTH - 1));
            empty       <= (wr_n == rd_n);
            overflow    <= overflow | (queue_we & full & ~pop);
            head        <= head_n;
        end
    end

endmodule
